// File: rtl/dm_store_rmw_pkg.sv
// Shared types and helpers for the store-side data-memory port.
package dm_store_rmw_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned BYTE_W = 8;

  // Store width encoding as issued by the MEM stage.
  typedef enum logic [1:0] {
    ST_WORD    = 2'b00,
    ST_HALF    = 2'b01,
    ST_BYTE    = 2'b10,
    ST_ILLEGAL = 2'b11
  } st_type_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_MERGE = 3'd2,
    S_WRITE = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  // Rejects misaligned word/half stores and the unused type encoding.
  function automatic logic is_bad_store(st_type_e t, logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (t)
      ST_WORD: bad = (off != 2'b00);
      ST_HALF: bad = off[0];
      ST_BYTE: bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dm_store_rmw_if.sv
// Store request channel between MEM-stage issue (master) and the store port (slave).
//   req_valid/req_ready : handshake, accept = valid & ready
//   req_type/addr/wdata : request payload, held stable by the master until accepted
//   done/err            : completion pulse, err marks a rejected request
interface dm_store_rmw_if;
  import dm_store_rmw_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_type;
  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              done;
  logic              err;

  modport master (
    output req_valid, req_type, req_addr, req_wdata,
    input  req_ready, done, err
  );

  modport slave (
    input  req_valid, req_type, req_addr, req_wdata,
    output req_ready, done, err
  );

endinterface

// File: rtl/dm_store_rmw_lane_merge.sv
// Combinational lane merge: drops store data into its byte/half lane of the old word.
//   old_word : word read back from the DM array
//   wdata    : store data low half (sb uses [7:0], sh uses [15:0])
//   st_type  : store width
//   byte_off : byte address bits [1:0], little-endian lanes
//   merged   : old word with the target lane replaced
module store_lane_merge
  import dm_store_rmw_pkg::*;
(
  input  logic [DATA_W-1:0] old_word,
  input  logic [HALF_W-1:0] wdata,
  input  st_type_e          st_type,
  input  logic [1:0]        byte_off,
  output logic [DATA_W-1:0] merged
);

  always_comb begin
    merged = old_word;
    case (st_type)
      ST_BYTE: begin
        case (byte_off)
          2'd0:    merged[7:0]   = wdata[BYTE_W-1:0];
          2'd1:    merged[15:8]  = wdata[BYTE_W-1:0];
          2'd2:    merged[23:16] = wdata[BYTE_W-1:0];
          default: merged[31:24] = wdata[BYTE_W-1:0];
        endcase
      end
      ST_HALF: begin
        if (byte_off[1]) merged[31:16] = wdata;
        else             merged[15:0]  = wdata;
      end
      default: merged = old_word;
    endcase
  end

endmodule

// File: rtl/dm_store_rmw.sv
// Store-side data-memory port: sw writes directly, sh/sb read-modify-write
// against a word-only DM with 1-cycle read latency, bad stores are rejected.
//   clk, reset : rising-edge clock, asynchronous active-low reset
//   req        : store request channel (slave side)
//   mem_addr   : DM word address
//   mem_rd_en  : DM read strobe, data on mem_rdata one cycle later
//   mem_rdata  : DM read data
//   mem_wr_en  : DM full-word write strobe
//   mem_wdata  : DM write data
module dm_store_rmw
  import dm_store_rmw_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic                clk,
  input  logic                reset,
  dm_store_rmw_if.slave       req,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_rd_en,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_wr_en,
  output logic [DATA_W-1:0]   mem_wdata
);

  state_e              state;
  st_type_e            type_q;
  logic [1:0]          off_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [HALF_W-1:0]   wdata_lo_q;
  logic [DATA_W-1:0]   merged_q;
  logic                ready_q;
  logic                done_q;
  logic                err_q;
  logic                rd_en_q;
  logic                wr_en_q;

  logic                accept;
  st_type_e            req_type_e;
  logic [DATA_W-1:0]   merge_word;

  // Address bits above the DM array are intentionally ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req.req_addr[DATA_W-1:ADDR_W+2];

  assign req_type_e = st_type_e'(req.req_type);
  assign accept     = req.req_valid & ready_q;

  store_lane_merge u_merge (
    .old_word (mem_rdata),
    .wdata    (wdata_lo_q),
    .st_type  (type_q),
    .byte_off (off_q),
    .merged   (merge_word)
  );

  // FSM with registered strobes: each output flop is loaded for the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      type_q     <= ST_WORD;
      off_q      <= 2'b00;
      addr_q     <= '0;
      wdata_lo_q <= '0;
      merged_q   <= '0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            addr_q     <= req.req_addr[ADDR_W+1:2];
            off_q      <= req.req_addr[1:0];
            type_q     <= req_type_e;
            wdata_lo_q <= req.req_wdata[HALF_W-1:0];
            if (is_bad_store(req_type_e, req.req_addr[1:0])) begin
              state  <= S_ERR;
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else if (req_type_e == ST_WORD) begin
              state    <= S_WRITE;
              merged_q <= req.req_wdata;
              wr_en_q  <= 1'b1;
              done_q   <= 1'b1;
            end else begin
              state   <= S_READ;
              rd_en_q <= 1'b1;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        S_READ: begin
          state <= S_MERGE;
        end
        // mem_rdata carries the word fetched in READ during this cycle.
        S_MERGE: begin
          state    <= S_WRITE;
          merged_q <= merge_word;
          wr_en_q  <= 1'b1;
          done_q   <= 1'b1;
        end
        S_WRITE, S_ERR: begin
          state   <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req.req_ready = ready_q;
  assign req.done      = done_q;
  assign req.err       = err_q;
  assign mem_addr      = addr_q;
  assign mem_rd_en     = rd_en_q;
  assign mem_wr_en     = wr_en_q;
  assign mem_wdata     = merged_q;

endmodule

// File: tb/tb_dm_store_rmw.sv
// Directed bench for dm_store_rmw: table of single stores plus reset-abort and back-to-back sequences.
module tb_dm_store_rmw;

  localparam int unsigned ADDR_W = 10;

  typedef struct {
    logic [1:0]        typ;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [31:0]       init;
    logic              exp_err;
    int                exp_lat;
    logic [ADDR_W-1:0] exp_addr;
    logic [31:0]       exp_wdata;
  } vec_t;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [31:0]       mem_rdata;
  logic              mem_wr_en;
  logic [31:0]       mem_wdata;

  logic              pl_en;
  logic [ADDR_W-1:0] pl_addr;
  logic [31:0]       pl_data;

  logic [31:0]       ram [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] log_addr [$];
  logic [31:0]       log_data [$];

  int errors;
  int checks;
  int both_hits;

  vec_t vecs [15];

  dm_store_rmw_if bus ();

  dm_store_rmw #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (bus),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_rdata (mem_rdata),
    .mem_wr_en (mem_wr_en),
    .mem_wdata (mem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DM model: registered read, full-word write, plus a bench-side preload port.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= ram[mem_addr];
    if (mem_wr_en) begin
      ram[mem_addr] <= mem_wdata;
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
    end else if (pl_en) begin
      ram[pl_addr] <= pl_data;
    end
  end

  always @(negedge clk) if (mem_rd_en && mem_wr_en) both_hits++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int done_c, rd_c, wr_c;
    logic err_s;
    logic [31:0] wd_s;
    logic [ADDR_W-1:0] wa_s;
    string tag;
    tag = $sformatf("vec%0d", idx);
    done_c = -1; rd_c = -1; wr_c = -1; err_s = 1'b0; wd_s = '0; wa_s = '0;
    if (!v.exp_err) preload(v.exp_addr, v.init);
    @(negedge clk);
    chk({tag, " ready_idle"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_type  = v.typ;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(negedge clk);
      if (bus.done && done_c < 0) begin done_c = k; err_s = bus.err; end
      if (mem_rd_en && rd_c < 0) rd_c = k;
      if (mem_wr_en && wr_c < 0) begin wr_c = k; wd_s = mem_wdata; wa_s = mem_addr; end
    end
    chk({tag, " done_cycle"}, 32'(done_c), 32'(v.exp_lat));
    chk({tag, " err"}, 32'(err_s), 32'(v.exp_err));
    if (v.exp_err) begin
      chk({tag, " no_read"}, 32'(rd_c), 32'hFFFF_FFFF);
      chk({tag, " no_write"}, 32'(wr_c), 32'hFFFF_FFFF);
    end else begin
      chk({tag, " write_cycle"}, 32'(wr_c), 32'(v.exp_lat));
      chk({tag, " read_cycle"}, 32'(rd_c), (v.exp_lat == 3) ? 32'd1 : 32'hFFFF_FFFF);
      chk({tag, " mem_addr"}, 32'(wa_s), 32'(v.exp_addr));
      chk({tag, " mem_wdata"}, wd_s, v.exp_wdata);
      chk({tag, " ram"}, ram[v.exp_addr], v.exp_wdata);
    end
  endtask

  initial begin
    logic bad;
    logic [31:0] b2b_d [4];
    int acc_n, last_acc;

    errors = 0; checks = 0; both_hits = 0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    bus.req_valid = 1'b0; bus.req_type = 2'b00; bus.req_addr = '0; bus.req_wdata = '0;

    vecs[0]  = '{2'b00, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 1, 10'h004, 32'hDEAD_BEEF};
    vecs[1]  = '{2'b10, 32'h0000_0013, 32'h0000_00AB, 32'h1122_3344, 1'b0, 3, 10'h004, 32'hAB22_3344};
    vecs[2]  = '{2'b01, 32'h0000_0012, 32'hFFFF_CAFE, 32'h1122_3344, 1'b0, 3, 10'h004, 32'hCAFE_3344};
    vecs[3]  = '{2'b01, 32'h0000_0010, 32'hFFFF_CAFE, 32'h1122_3344, 1'b0, 3, 10'h004, 32'h1122_CAFE};
    vecs[4]  = '{2'b10, 32'h0000_0010, 32'hFFFF_FF5A, 32'h1122_3344, 1'b0, 3, 10'h004, 32'h1122_335A};
    vecs[5]  = '{2'b10, 32'h0000_0011, 32'h0000_0077, 32'h1122_3344, 1'b0, 3, 10'h004, 32'h1122_7744};
    vecs[6]  = '{2'b10, 32'h0000_0012, 32'h0000_0099, 32'h1122_3344, 1'b0, 3, 10'h004, 32'h1199_3344};
    vecs[7]  = '{2'b00, 32'h0000_0011, 32'h0000_0001, 32'h0000_0000, 1'b1, 1, 10'h000, 32'h0000_0000};
    vecs[8]  = '{2'b01, 32'h0000_0013, 32'h0000_1234, 32'h0000_0000, 1'b1, 1, 10'h000, 32'h0000_0000};
    vecs[9]  = '{2'b11, 32'h0000_0010, 32'h0000_5678, 32'h0000_0000, 1'b1, 1, 10'h000, 32'h0000_0000};
    vecs[10] = '{2'b01, 32'h0000_0011, 32'h0000_1234, 32'h0000_0000, 1'b1, 1, 10'h000, 32'h0000_0000};
    vecs[11] = '{2'b00, 32'h0000_0012, 32'h0000_1234, 32'h0000_0000, 1'b1, 1, 10'h000, 32'h0000_0000};
    vecs[12] = '{2'b00, 32'hFFFF_F008, 32'h1234_5678, 32'h0000_0000, 1'b0, 1, 10'h002, 32'h1234_5678};
    vecs[13] = '{2'b10, 32'h8000_0021, 32'h0000_00CC, 32'hA5A5_A5A5, 1'b0, 3, 10'h008, 32'hA5A5_CCA5};
    vecs[14] = '{2'b01, 32'h0000_0FFE, 32'h0000_1234, 32'h0000_FFFF, 1'b0, 3, 10'h3FF, 32'h1234_FFFF};

    // Reset state.
    reset = 1'b1;
    #1 reset = 1'b0;
    #20;
    chk("reset strobes", 32'({bus.req_ready, bus.done, bus.err, mem_rd_en, mem_wr_en}), 32'd0);
    chk("reset mem_addr", 32'(mem_addr), 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("ready after reset", 32'(bus.req_ready), 32'd1);

    for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

    // Reset asserted while an sb sits in MERGE: write must never issue.
    preload(10'h004, 32'h1122_3344);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_type = 2'b10; bus.req_addr = 32'h13; bus.req_wdata = 32'h55;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("abort read strobe", 32'(mem_rd_en), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort outputs", 32'({bus.req_ready, bus.done, bus.err, mem_rd_en, mem_wr_en}), 32'd0);
    bad = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (mem_wr_en || bus.done) bad = 1'b1;
    end
    reset = 1'b1;
    @(negedge clk);
    if (mem_wr_en || bus.done) bad = 1'b1;
    chk("abort no write/done", 32'(bad), 32'd0);
    chk("abort ready after release", 32'(bus.req_ready), 32'd1);
    chk("abort ram intact", ram[4], 32'h1122_3344);
    run_vec('{2'b00, 32'h0000_0010, 32'h0BAD_F00D, 32'h1122_3344, 1'b0, 1, 10'h004, 32'h0BAD_F00D}, 99);

    // Back-to-back sw with req_valid held high.
    b2b_d[0] = 32'hC0DE_0000; b2b_d[1] = 32'hC0DE_1111;
    b2b_d[2] = 32'hC0DE_2222; b2b_d[3] = 32'hC0DE_3333;
    log_addr.delete(); log_data.delete();
    acc_n = 0; last_acc = -1;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_type = 2'b00; bus.req_addr = 32'h20; bus.req_wdata = b2b_d[0];
    for (int c = 0; c < 40 && acc_n < 4; c++) begin
      if (bus.done) chk("b2b ready low on done", 32'(bus.req_ready), 32'd0);
      if (bus.req_ready) begin
        if (last_acc >= 0) chk("b2b accept spacing", 32'(c - last_acc), 32'd2);
        last_acc = c;
        acc_n++;
        @(negedge clk);
        if (acc_n < 4) begin
          bus.req_addr  = 32'h20 + 32'(4 * acc_n);
          bus.req_wdata = b2b_d[acc_n];
        end else begin
          bus.req_valid = 1'b0;
        end
      end else begin
        @(negedge clk);
      end
    end
    chk("b2b accepts", 32'(acc_n), 32'd4);
    repeat (4) @(negedge clk);
    chk("b2b write count", 32'(log_addr.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < log_addr.size()) begin
        chk($sformatf("b2b write%0d addr", i), 32'(log_addr[i]), 32'(8 + i));
        chk($sformatf("b2b write%0d data", i), log_data[i], b2b_d[i]);
      end
    end

    chk("rd/wr strobes never both high", 32'(both_hits), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
